// File: rtl/ram_arbiter.sv
// rtl/ram_arbiter.sv - two-port arbiter in front of a single-port 256x16 RAM
//
// Port A (CPU) and port B (loader/DMA/debug) share one RAM with a 1-cycle
// registered read. Only RAM-range requests (addr[ADDR_W-1]==0) with cmd[1]==1
// are served. A write completes in the ACC cycle; a read completes in the
// following RD_WAIT cycle, when mem_dout carries the data.
//
// Optional feature macro: ARB_ROUND_ROBIN_EN
//   defined   : ties in IDLE go to the port not served last (A after reset)
//   undefined : fixed priority, A wins every tie
//
// Ports:
//   clk, reset                         clock, synchronous active-high reset
//   a_cmd/b_cmd       [1:0]            2'b10 read, 2'b11 write, else no request
//   a_addr/b_addr     [ADDR_W-1:0]     request address
//   a_wdata/b_wdata   [DATA_W-1:0]     write data
//   a_done/b_done                      1-cycle completion pulse
//   a_rvalid/b_rvalid                  1-cycle read-data-valid pulse
//   a_rdata/b_rdata   [DATA_W-1:0]     mem_dout while rvalid, else 0
//   mem_read_address/mem_write_address [RAM_AW-1:0]
//   mem_write, mem_din [DATA_W-1:0], mem_dout [DATA_W-1:0]
//   grant             [1:0]            {B,A} one-hot owner, 0 when idle
module ram_arbiter #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 9,
    parameter int RAM_AW = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [1:0]        a_cmd,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [DATA_W-1:0] a_wdata,
    input  logic [1:0]        b_cmd,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [DATA_W-1:0] b_wdata,
    output logic              a_done,
    output logic              a_rvalid,
    output logic [DATA_W-1:0] a_rdata,
    output logic              b_done,
    output logic              b_rvalid,
    output logic [DATA_W-1:0] b_rdata,
    output logic [RAM_AW-1:0] mem_read_address,
    output logic [RAM_AW-1:0] mem_write_address,
    output logic              mem_write,
    output logic [DATA_W-1:0] mem_din,
    input  logic [DATA_W-1:0] mem_dout,
    output logic [1:0]        grant
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACC_A   = 2'd1,
        ACC_B   = 2'd2,
        RD_WAIT = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic              owner_q, owner_d;   // 0 = A, 1 = B
    logic              wr_q, wr_d;         // current access is a write
    logic [RAM_AW-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] din_q, din_d;
`ifdef ARB_ROUND_ROBIN_EN
    logic              last_q, last_d;     // 0 = A served last, 1 = B
`endif

    logic a_valid, b_valid, take_b;
    logic in_acc, active, done_now, rvalid_now;

    assign a_valid = a_cmd[1] & ~a_addr[ADDR_W-1];
    assign b_valid = b_cmd[1] & ~b_addr[ADDR_W-1];

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        wr_d    = wr_q;
        addr_d  = addr_q;
        din_d   = din_q;
`ifdef ARB_ROUND_ROBIN_EN
        last_d  = last_q;
        take_b  = (a_valid && b_valid) ? ~last_q : (b_valid && !a_valid);
`else
        take_b  = b_valid && !a_valid;
`endif
        case (state_q)
            IDLE: begin
                if (a_valid || b_valid) begin
                    // Capture the winner's request so the RAM sees stable
                    // address/data for the whole access and keeps them after.
                    owner_d = take_b;
                    state_d = take_b ? ACC_B : ACC_A;
                    wr_d    = take_b ? b_cmd[0] : a_cmd[0];
                    addr_d  = take_b ? b_addr[RAM_AW-1:0] : a_addr[RAM_AW-1:0];
                    din_d   = take_b ? b_wdata : a_wdata;
`ifdef ARB_ROUND_ROBIN_EN
                    last_d  = take_b;
`endif
                end
            end
            ACC_A, ACC_B: state_d = wr_q ? IDLE : RD_WAIT;
            RD_WAIT:      state_d = IDLE;
            default:      state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            owner_q <= 1'b0;
            wr_q    <= 1'b0;
            addr_q  <= '0;
            din_q   <= '0;
`ifdef ARB_ROUND_ROBIN_EN
            last_q  <= 1'b1;
`endif
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            wr_q    <= wr_d;
            addr_q  <= addr_d;
            din_q   <= din_d;
`ifdef ARB_ROUND_ROBIN_EN
            last_q  <= last_d;
`endif
        end
    end

    // Strobes are gated by reset so an access cut short by reset never
    // writes the RAM or reports completion.
    always_comb begin
        in_acc     = (state_q == ACC_A) || (state_q == ACC_B);
        active     = in_acc || (state_q == RD_WAIT);
        done_now   = ~reset & ((in_acc & wr_q) | (state_q == RD_WAIT));
        rvalid_now = ~reset & (state_q == RD_WAIT);

        grant      = (active && !reset) ? (owner_q ? 2'b10 : 2'b01) : 2'b00;
        mem_write  = in_acc & wr_q & ~reset;

        a_done     = done_now & ~owner_q;
        b_done     = done_now & owner_q;
        a_rvalid   = rvalid_now & ~owner_q;
        b_rvalid   = rvalid_now & owner_q;
        a_rdata    = a_rvalid ? mem_dout : '0;
        b_rdata    = b_rvalid ? mem_dout : '0;
    end

    assign mem_read_address  = addr_q;
    assign mem_write_address = addr_q;
    assign mem_din           = din_q;

endmodule

// File: tb/tb_ram_arbiter.sv
// tb/tb_ram_arbiter.sv - directed self-checking bench for ram_arbiter
module tb_ram_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  a_cmd, b_cmd;
    logic [8:0]  a_addr, b_addr;
    logic [15:0] a_wdata, b_wdata;
    logic        a_done, a_rvalid, b_done, b_rvalid;
    logic [15:0] a_rdata, b_rdata;
    logic [7:0]  mem_read_address, mem_write_address;
    logic        mem_write;
    logic [15:0] mem_din;
    logic [15:0] mem_dout = 16'h0;
    logic [1:0]  grant;

    int vectors = 0;
    int errs    = 0;

    logic [15:0] ram [0:255];

    ram_arbiter dut (
        .clk(clk), .reset(reset),
        .a_cmd(a_cmd), .a_addr(a_addr), .a_wdata(a_wdata),
        .b_cmd(b_cmd), .b_addr(b_addr), .b_wdata(b_wdata),
        .a_done(a_done), .a_rvalid(a_rvalid), .a_rdata(a_rdata),
        .b_done(b_done), .b_rvalid(b_rvalid), .b_rdata(b_rdata),
        .mem_read_address(mem_read_address), .mem_write_address(mem_write_address),
        .mem_write(mem_write), .mem_din(mem_din), .mem_dout(mem_dout),
        .grant(grant)
    );

    always #5 clk = ~clk;

    // Single-port RAM with registered read
    always @(posedge clk) begin
        if (mem_write) ram[mem_write_address] <= mem_din;
        mem_dout <= ram[mem_read_address];
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, ".grant"}, {14'h0, grant}, 16'h0);
        chk({tag, ".a_done"}, {15'h0, a_done}, 16'h0);
        chk({tag, ".b_done"}, {15'h0, b_done}, 16'h0);
        chk({tag, ".a_rvalid"}, {15'h0, a_rvalid}, 16'h0);
        chk({tag, ".b_rvalid"}, {15'h0, b_rvalid}, 16'h0);
        chk({tag, ".a_rdata"}, a_rdata, 16'h0);
        chk({tag, ".b_rdata"}, b_rdata, 16'h0);
        chk({tag, ".mem_write"}, {15'h0, mem_write}, 16'h0);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) ram[i] = 16'h0;
        reset = 1'b1;
        a_cmd = 2'b00; a_addr = 9'h0; a_wdata = 16'h0;
        b_cmd = 2'b00; b_addr = 9'h0; b_wdata = 16'h0;
        step(); step();
        reset = 1'b0;
        // Reset state
        chk_quiet("rst");
        chk("rst.raddr", {8'h0, mem_read_address}, 16'h0);
        chk("rst.waddr", {8'h0, mem_write_address}, 16'h0);
        chk("rst.din", mem_din, 16'h0);

        // 1: A write 0x012 <- 0xBEEF
        a_cmd = 2'b11; a_addr = 9'h012; a_wdata = 16'hBEEF;
        step();
        a_cmd = 2'b00;
        chk("t1.mem_write", {15'h0, mem_write}, 16'h1);
        chk("t1.waddr", {8'h0, mem_write_address}, 16'h0012);
        chk("t1.din", mem_din, 16'hBEEF);
        chk("t1.a_done", {15'h0, a_done}, 16'h1);
        chk("t1.a_rvalid", {15'h0, a_rvalid}, 16'h0);
        chk("t1.grant", {14'h0, grant}, 16'h1);
        step();
        chk_quiet("t1.idle");
        chk("t1.hold_addr", {8'h0, mem_write_address}, 16'h0012);

        // 2: A read 0x012
        a_cmd = 2'b10; a_addr = 9'h012;
        step();
        a_cmd = 2'b00;
        chk("t2.acc.grant", {14'h0, grant}, 16'h1);
        chk("t2.acc.a_done", {15'h0, a_done}, 16'h0);
        chk("t2.acc.mem_write", {15'h0, mem_write}, 16'h0);
        chk("t2.acc.raddr", {8'h0, mem_read_address}, 16'h0012);
        step();
        chk("t2.a_rvalid", {15'h0, a_rvalid}, 16'h1);
        chk("t2.a_done", {15'h0, a_done}, 16'h1);
        chk("t2.a_rdata", a_rdata, 16'hBEEF);
        chk("t2.b_rvalid", {15'h0, b_rvalid}, 16'h0);
        chk("t2.b_rdata", b_rdata, 16'h0);
        chk("t2.grant", {14'h0, grant}, 16'h1);
        step();
        chk_quiet("t2.idle");

        // 3: contention, A read 0x05 vs B write 0x06 <- 0x1234 (fresh reset: A wins first tie)
        reset = 1'b1;
        step();
        reset = 1'b0;
        a_cmd = 2'b10; a_addr = 9'h005;
        b_cmd = 2'b11; b_addr = 9'h006; b_wdata = 16'h1234;
        step();
        chk("t3.first.grant", {14'h0, grant}, 16'h1);
        chk("t3.first.b_done", {15'h0, b_done}, 16'h0);
        step();
        chk("t3.first.a_done", {15'h0, a_done}, 16'h1);
        chk("t3.first.a_rdata", a_rdata, 16'h0);
        step();
        chk("t3.gap.grant", {14'h0, grant}, 16'h0);
`ifdef ARB_ROUND_ROBIN_EN
        step();
        chk("t3.rr.second.grant", {14'h0, grant}, 16'h2);
        chk("t3.rr.second.b_done", {15'h0, b_done}, 16'h1);
        chk("t3.rr.second.waddr", {8'h0, mem_write_address}, 16'h0006);
        chk("t3.rr.second.din", mem_din, 16'h1234);
        step();
        step();
        chk("t3.rr.third.grant", {14'h0, grant}, 16'h1);
        a_cmd = 2'b00; b_cmd = 2'b00;
        step();
        chk("t3.rr.third.a_done", {15'h0, a_done}, 16'h1);
        step();
`else
        step();
        chk("t3.fp.second.grant", {14'h0, grant}, 16'h1);
        step();
        chk("t3.fp.second.a_done", {15'h0, a_done}, 16'h1);
        chk("t3.fp.second.b_done", {15'h0, b_done}, 16'h0);
        a_cmd = 2'b00;
        step();
        chk("t3.fp.gap2.grant", {14'h0, grant}, 16'h0);
        step();
        chk("t3.fp.b.grant", {14'h0, grant}, 16'h2);
        chk("t3.fp.b.b_done", {15'h0, b_done}, 16'h1);
        chk("t3.fp.b.mem_write", {15'h0, mem_write}, 16'h1);
        chk("t3.fp.b.waddr", {8'h0, mem_write_address}, 16'h0006);
        chk("t3.fp.b.din", mem_din, 16'h1234);
        chk("t3.fp.b.a_done", {15'h0, a_done}, 16'h0);
        b_cmd = 2'b00;
        step();
`endif
        chk_quiet("t3.idle");

        // 4: I/O-range requests are ignored
        a_cmd = 2'b10; a_addr = 9'h140;
        b_cmd = 2'b11; b_addr = 9'h100; b_wdata = 16'h5555;
        step();
        chk_quiet("t4.c1");
        step();
        chk_quiet("t4.c2");
        a_cmd = 2'b00; b_cmd = 2'b00;

        // 5: B read, reset in RD_WAIT
        b_cmd = 2'b10; b_addr = 9'h012;
        step();
        b_cmd = 2'b00;
        chk("t5.acc.grant", {14'h0, grant}, 16'h2);
        reset = 1'b1;
        step();
        chk("t5.rd.b_rvalid", {15'h0, b_rvalid}, 16'h0);
        chk("t5.rd.b_done", {15'h0, b_done}, 16'h0);
        chk("t5.rd.b_rdata", b_rdata, 16'h0);
        chk("t5.rd.grant", {14'h0, grant}, 16'h0);
        reset = 1'b0;
        step();
        chk_quiet("t5.after");
        chk("t5.after.raddr", {8'h0, mem_read_address}, 16'h0);
        chk("t5.after.din", mem_din, 16'h0);

        // 6: B pre-writes 0xFF <- 0xAAAA, then A write 0xFF aborted by reset
        b_cmd = 2'b11; b_addr = 9'h0FF; b_wdata = 16'hAAAA;
        step();
        b_cmd = 2'b00;
        chk("t6.pre.b_done", {15'h0, b_done}, 16'h1);
        step();
        a_cmd = 2'b11; a_addr = 9'h0FF; a_wdata = 16'h0001;
        step();
        a_cmd = 2'b00;
        reset = 1'b1;
        #1;
        chk("t6.rst.mem_write", {15'h0, mem_write}, 16'h0);
        chk("t6.rst.a_done", {15'h0, a_done}, 16'h0);
        step();
        reset = 1'b0;
        a_cmd = 2'b10; a_addr = 9'h0FF;
        step();
        a_cmd = 2'b00;
        step();
        chk("t6.rd.a_rvalid", {15'h0, a_rvalid}, 16'h1);
        chk("t6.rd.a_rdata", a_rdata, 16'hAAAA);
        step();
        chk_quiet("t6.idle");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

endmodule
